token_matcher: RTL and testbench
================================

TOKEN_MATCHER -- requirements
Module: token_matcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: vocabulary depth 2^ADDR_WIDTH entries.
REQ-002 SHALL have parameter WORD_LENGTH, default 3: characters per entry.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: bits per character.
REQ-004 SHALL have clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have wr_en / wr_addr / wr_data, input, 1 / ADDR_WIDTH / WORD_LENGTH*DATA_WIDTH: vocabulary write port.
REQ-007 SHALL have req_valid / req_ready, input / output, 1 each: query handshake.
REQ-008 SHALL have req_word, input, WORD_LENGTH*DATA_WIDTH: query; char 0 in the MSBs.
REQ-009 SHALL have req_len, input, $clog2(WORD_LENGTH+1): number of significant leading chars.
REQ-010 SHALL have req_start_addr / req_end_addr, input, ADDR_WIDTH each: inclusive scan range.
REQ-011 SHALL have rsp_valid / rsp_ready, output / input, 1 each: result handshake.
REQ-012 SHALL have rsp_status, output, 2: 00 hit, 01 null entry, 10 range exhausted, 11 bad length.
REQ-013 SHALL have rsp_index, output, ADDR_WIDTH: address of the hit or last entry examined.

Function
REQ-014 SHALL hold internal vocabulary RAM: 1 write + 1 read port, 1-cycle synchronous read, read-first on same-address collision.
REQ-015 SHALL write wr_data to wr_addr on any edge with wr_en=1, in every state, including during a scan.
REQ-016 SHALL implement FSM IDLE, READ, CMP, DONE.
REQ-017 SHALL drive req_ready=1 only in IDLE; a query is accepted on an edge with req_valid&&req_ready; req_word, req_len and range are latched at acceptance.
REQ-018 SHALL, on acceptance with req_len=0 or req_len>WORD_LENGTH, go directly to DONE with status 11 and rsp_index=req_start_addr.
REQ-019 SHALL otherwise go to READ with curr_addr=req_start_addr; READ issues read of curr_addr, next state CMP.
REQ-020 SHALL in CMP compare the top req_len chars of RAM dout with those of the latched word; remaining chars are ignored.
REQ-021 SHALL priority in CMP: match -> DONE status 00; else dout all-zero (null terminator) -> DONE status 01; else curr_addr==end_addr -> DONE status 10; else curr_addr+1 and READ.
REQ-022 SHALL wrap curr_addr modulo 2^ADDR_WIDTH; start>end scans start..max, 0..end; start==end scans exactly one entry.
REQ-023 SHALL set rsp_index=curr_addr of the deciding CMP cycle.
REQ-024 SHALL, for a hit at offset k from start, assert rsp_valid after edge 2k+2 counted from the acceptance edge (edge 0).
REQ-025 SHALL hold rsp_valid, rsp_status, rsp_index stable in DONE until rsp_valid&&rsp_ready, then return to IDLE; req_ready rises on the following cycle.
REQ-026 SHALL give the null-entry check lower priority than the match check (an all-zero query with req_len>0 hits a zero entry).

Reset
REQ-027 SHALL on rst_n=0 at an edge force IDLE, req_ready=1, rsp_valid=0, rsp_status=00, rsp_index=0, curr_addr=0.
REQ-028 SHALL abort any scan or pending response on reset mid-operation without producing a response.
REQ-029 SHALL not clear RAM contents on reset; unwritten entries are undefined and the bench initialises all entries before querying.
REQ-030 SHALL still honour wr_en during reset.

Verification
REQ-031 SHALL test hit: entries 0..2 = 0x414243, 0x48656C, 0x000000, query 0x48656C, len 3, range 0..15 -> status 00, index 1, rsp_valid after edge 4.
REQ-032 SHALL test prefix: same RAM, query 0x486500, len 2 -> status 00, index 1; with len 3 -> status 01, index 2.
REQ-033 SHALL test wrap: all entries 0x111111 except entry 1 = 0x48656C, range 14..2, query 0x48656C, len 3 -> status 00, index 1, after edge 8; query 0x999999 -> status 10, index 2.
REQ-034 SHALL test bad length: req_len=0 or 4 -> status 11, index=start, rsp_valid after edge 1.
REQ-035 SHALL test backpressure plus reset: hold rsp_ready=0 for 5 cycles -> outputs stable; pulse rst_n=0 mid-scan -> rsp_valid=0, req_ready=1 next cycle, no stale response.
REQ-036 SHALL test write during scan: rewrite entry 3 to the query word while scanning entry 1 -> status 00, index 3.

Source files
------------

// File: rtl/token_matcher.sv
// token_matcher: vocabulary lookup engine. Scans an inclusive, wrapping address
// range of an internal word RAM for the first entry whose leading req_len
// characters match the query. The scan stops early at a null (all-zero) entry.
module token_matcher #(
  parameter  int ADDR_WIDTH  = 4,
  parameter  int WORD_LENGTH = 3,
  parameter  int DATA_WIDTH  = 8,
  localparam int WORD_W      = WORD_LENGTH * DATA_WIDTH,
  localparam int LEN_W       = $clog2(WORD_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_W-1:0]     req_word,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [ADDR_WIDTH-1:0] req_start_addr,
  input  logic [ADDR_WIDTH-1:0] req_end_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_index
);

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  localparam logic [1:0] ST_HIT     = 2'b00;
  localparam logic [1:0] ST_NULL    = 2'b01;
  localparam logic [1:0] ST_EXHAUST = 2'b10;
  localparam logic [1:0] ST_BAD_LEN = 2'b11;

  state_t state, next_state;

  logic [WORD_W-1:0]     mem [2**ADDR_WIDTH];
  logic [WORD_W-1:0]     dout;
  logic [WORD_W-1:0]     word_q;
  logic [LEN_W-1:0]      len_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [ADDR_WIDTH-1:0] curr_addr;

  logic bad_len;
  logic is_match;
  logic is_null;
  logic at_end;

  // Vocabulary RAM: one write port and a registered read issued from READ.
  // NOTE: the RAM array is deliberately not reset; clearing it would cost a
  // clear sequencer for no benefit, and writes keep working while rst_n is low.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    // Read-first on a same-address collision falls out of non-blocking updates.
    if (state == READ) dout <= mem[curr_addr];
  end

  // Query length is legal only for 1..WORD_LENGTH characters.
  assign bad_len = (req_len == '0) || (int'(req_len) > WORD_LENGTH);
  assign is_null = (dout == '0);
  assign at_end  = (curr_addr == end_q);

  // Compare only the leading len_q characters; char 0 sits in the MSBs.
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    is_match = 1'b1;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (i < int'(len_q)) begin
        if (dout[(WORD_LENGTH-i)*DATA_WIDTH-1 -: DATA_WIDTH] !=
            word_q[(WORD_LENGTH-i)*DATA_WIDTH-1 -: DATA_WIDTH]) begin
          is_match = 1'b0;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = bad_len ? DONE : READ;
      READ: next_state = CMP;
      CMP:  next_state = (is_match || is_null || at_end) ? DONE : READ;
      DONE: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
  end

  // Scan datapath: latch the query, step the address, record the verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      len_q      <= '0;
      end_q      <= '0;
      curr_addr  <= '0;
      rsp_status <= ST_HIT;
      rsp_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            word_q    <= req_word;
            len_q     <= req_len;
            end_q     <= req_end_addr;
            curr_addr <= req_start_addr;
            if (bad_len) begin
              rsp_status <= ST_BAD_LEN;
              rsp_index  <= req_start_addr;
            end
          end
        end
        CMP: begin
          rsp_index <= curr_addr;
          if (is_match)    rsp_status <= ST_HIT;
          else if (is_null) rsp_status <= ST_NULL;
          else if (at_end)  rsp_status <= ST_EXHAUST;
          else              curr_addr  <= curr_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_token_matcher.sv
// tb_token_matcher: directed vectors with hand-computed expectations for the
// token_matcher scan engine at default parameters (16 x 3 x 8-bit entries).
module tb_token_matcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_word;
  logic [1:0]  req_len;
  logic [3:0]  req_start_addr;
  logic [3:0]  req_end_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_index;

  int n_vec = 0;
  int n_err = 0;

  token_matcher dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_word       (req_word),
    .req_len        (req_len),
    .req_start_addr (req_start_addr),
    .req_end_addr   (req_end_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_status     (rsp_status),
    .rsp_index      (rsp_index)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic fill(input logic [23:0] data);
    for (int a = 0; a < 16; a++) write_entry(4'(a), data);
  endtask

  // Issue one query from IDLE and check the response. exp_lat is the edge
  // (acceptance = edge 0) after which rsp_valid first reads high; a negative
  // exp_lat means only check that rsp_valid is high after edge 1.
  task automatic run_query(input string tag, input logic [23:0] word, input logic [1:0] len,
                           input logic [3:0] s, input logic [3:0] e,
                           input logic [1:0] exp_st, input logic [3:0] exp_idx,
                           input int exp_lat, input int hold);
    int n;
    req_word       = word;
    req_len        = len;
    req_start_addr = s;
    req_end_addr   = e;
    req_valid      = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while ((!rsp_valid || (exp_lat < 0 && n < 1)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_lat >= 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
    else              check({tag, " valid_after_edge1"}, 32'(rsp_valid), 32'd1);
    check({tag, " status"}, 32'(rsp_status), 32'(exp_st));
    check({tag, " index"},  32'(rsp_index),  32'(exp_idx));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " held valid"},  32'(rsp_valid),  32'd1);
      check({tag, " held status"}, 32'(rsp_status), 32'(exp_st));
      check({tag, " held index"},  32'(rsp_index),  32'(exp_idx));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " valid dropped"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready back"},    32'(req_ready), 32'd1);
  endtask

  initial begin
    int vis;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_word = '0; req_len = '0;
    req_start_addr = '0; req_end_addr = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;

    // RAM is loaded while reset is held low: writes must still land.
    fill(24'h555555);
    write_entry(4'd0, 24'h414243);
    write_entry(4'd1, 24'h48656C);
    write_entry(4'd2, 24'h000000);
    check("reset req_ready",  32'(req_ready),  32'd1);
    check("reset rsp_valid",  32'(rsp_valid),  32'd0);
    check("reset rsp_status", 32'(rsp_status), 32'd0);
    check("reset rsp_index",  32'(rsp_index),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_query("hit0",        24'h414243, 2'd3, 4'd0, 4'd15, 2'b00, 4'd0, 2, 0);
    run_query("hit1_bp",     24'h48656C, 2'd3, 4'd0, 4'd15, 2'b00, 4'd1, 4, 5);
    run_query("prefix_len2", 24'h486500, 2'd2, 4'd0, 4'd15, 2'b00, 4'd1, 4, 0);
    run_query("prefix_len3", 24'h486500, 2'd3, 4'd0, 4'd15, 2'b01, 4'd2, 6, 0);
    run_query("zero_query",  24'h000000, 2'd1, 4'd0, 4'd15, 2'b00, 4'd2, 6, 0);
    run_query("badlen_s5",   24'h414243, 2'd0, 4'd5, 4'd9,  2'b11, 4'd5, -1, 0);
    run_query("badlen_s12",  24'h48656C, 2'd0, 4'd12, 4'd3, 2'b11, 4'd12, -1, 0);

    fill(24'h111111);
    write_entry(4'd1, 24'h48656C);
    run_query("wrap_hit",  24'h48656C, 2'd3, 4'd14, 4'd2, 2'b00, 4'd1, 8, 0);
    run_query("wrap_miss", 24'h999999, 2'd3, 4'd14, 4'd2, 2'b10, 4'd2, 10, 0);

    // Single-entry range; entry 0 is overwritten on the very edge it is read,
    // so the read returns the old value and the scan is exhausted.
    fork
      run_query("collide", 24'h333333, 2'd3, 4'd0, 4'd0, 2'b10, 4'd0, 2, 0);
      begin
        @(posedge clk); #1;
        write_entry(4'd0, 24'h333333);
      end
    join
    run_query("after_collide", 24'h333333, 2'd3, 4'd0, 4'd0, 2'b00, 4'd0, 2, 0);

    // Entry 3 rewritten to the query word on the edge that reads entry 1.
    fork
      run_query("wr_during_scan", 24'h222222, 2'd3, 4'd0, 4'd15, 2'b00, 4'd3, 8, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        write_entry(4'd3, 24'h222222);
      end
    join

    // Reset pulse in the middle of a long scan.
    req_word = 24'h999999; req_len = 2'd3; req_start_addr = 4'd0; req_end_addr = 4'd15;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset rsp_valid",  32'(rsp_valid),  32'd0);
    check("midreset req_ready",  32'(req_ready),  32'd1);
    check("midreset rsp_status", 32'(rsp_status), 32'd0);
    check("midreset rsp_index",  32'(rsp_index),  32'd0);
    vis = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) vis++;
    end
    check("midreset stale rsp", 32'(vis), 32'd0);
    run_query("post_reset", 24'h222222, 2'd3, 4'd0, 4'd15, 2'b00, 4'd3, 8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
